// File: rtl/quadro_peso_rx.sv
// Receiver for ASCII weight frames "<min><max><atual>#": classifies atual against [min, max].
// Optional macro QUADRO_CHECA_FAIXA_EN rejects frames whose min exceeds max.
module quadro_peso_rx #(
    parameter int DIGITOS        = 2,
    parameter int TIMEOUT_CICLOS = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             dado,
    input  logic                   dado_valido,
    output logic                   pronto,
    output logic                   erro,
    output logic                   pertence,
    output logic                   abaixo,
    output logic                   acima,
    output logic                   peso_max_zero,
    output logic [2:0]             posicao,
    output logic [4*DIGITOS-1:0]   peso_atual,
    output logic [1:0]             db_estado
);

    localparam int CW   = 4*DIGITOS;
    localparam int FW   = 12*DIGITOS;
    localparam int NDIG = 3*DIGITOS;
    localparam int NW   = $clog2(NDIG+1);
    localparam int TW   = $clog2(TIMEOUT_CICLOS+1);
    localparam logic [NW-1:0] ULTIMO_DIGITO = NW'(NDIG-1);
    localparam logic [TW-1:0] TIMEOUT_FIM   = TW'(TIMEOUT_CICLOS-1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        RECEBE      = 2'b01,
        AGUARDA_FIM = 2'b10
    } estado_t;

    estado_t          r_estado;
    logic [NW-1:0]    r_cont;
    logic [TW-1:0]    r_timeout;
    logic [FW-1:0]    r_campos;
    logic             r_pronto, r_erro;
    logic             r_pertence, r_abaixo, r_acima, r_peso_max_zero;
    logic [2:0]       r_posicao;
    logic [CW-1:0]    r_peso_atual;

    logic             w_digito, w_hash, w_expirou, w_faixa_ok;
    logic             w_acima, w_abaixo;
    logic [3:0]       w_bcd;
    logic [CW-1:0]    w_min, w_max, w_atual;

    assign w_digito = (dado >= 8'h30) && (dado <= 8'h39);
    assign w_hash   = (dado == 8'h23);
    assign w_bcd    = dado[3:0];
    assign w_min    = r_campos[FW-1 -: CW];
    assign w_max    = r_campos[2*CW-1 -: CW];
    assign w_atual  = r_campos[CW-1:0];
    assign w_acima  = (w_atual > w_max);
    assign w_abaixo = (w_atual < w_min);
    // A byte arriving on the terminal cycle wins over the timeout.
    assign w_expirou = (r_estado != OCIOSO) && !dado_valido && (r_timeout == TIMEOUT_FIM);

`ifdef QUADRO_CHECA_FAIXA_EN
    assign w_faixa_ok = (w_min <= w_max);
`else
    assign w_faixa_ok = 1'b1;
`endif

    // NOTE: non-blocking assignments throughout, so every decision below sees pre-edge state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado        <= OCIOSO;
            r_cont          <= '0;
            r_timeout       <= '0;
            r_campos        <= '0;
            r_pronto        <= 1'b0;
            r_erro          <= 1'b0;
            r_pertence      <= 1'b0;
            r_abaixo        <= 1'b0;
            r_acima         <= 1'b0;
            r_peso_max_zero <= 1'b1;
            r_posicao       <= 3'b000;
            r_peso_atual    <= '0;
        end else begin
            r_pronto <= 1'b0;
            r_erro   <= 1'b0;

            if (r_estado == OCIOSO || dado_valido || w_expirou)
                r_timeout <= '0;
            else
                r_timeout <= r_timeout + 1'b1;

            case (r_estado)
                OCIOSO: begin
                    if (dado_valido && w_digito) begin
                        r_campos <= FW'(w_bcd);
                        r_cont   <= NW'(1);
                        r_estado <= RECEBE;
                    end else begin
                        r_cont <= '0;
                    end
                end
                RECEBE: begin
                    if (dado_valido) begin
                        if (w_digito) begin
                            r_campos <= {r_campos[FW-5:0], w_bcd};
                            r_cont   <= r_cont + 1'b1;
                            if (r_cont == ULTIMO_DIGITO)
                                r_estado <= AGUARDA_FIM;
                        end else begin
                            r_erro   <= 1'b1;
                            r_estado <= OCIOSO;
                        end
                    end else if (w_expirou) begin
                        r_erro   <= 1'b1;
                        r_estado <= OCIOSO;
                    end
                end
                AGUARDA_FIM: begin
                    if (dado_valido) begin
                        r_estado <= OCIOSO;
                        if (w_hash && w_faixa_ok) begin
                            r_pronto        <= 1'b1;
                            r_acima         <= w_acima;
                            r_abaixo        <= !w_acima && w_abaixo;
                            r_pertence      <= !w_acima && !w_abaixo;
                            r_posicao       <= w_acima ? 3'b111 : (w_abaixo ? 3'b000 : 3'b011);
                            r_peso_max_zero <= (w_max == '0);
                            r_peso_atual    <= w_atual;
                        end else begin
                            r_erro <= 1'b1;
                        end
                    end else if (w_expirou) begin
                        r_erro   <= 1'b1;
                        r_estado <= OCIOSO;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign pronto        = r_pronto;
    assign erro          = r_erro;
    assign pertence      = r_pertence;
    assign abaixo        = r_abaixo;
    assign acima         = r_acima;
    assign peso_max_zero = r_peso_max_zero;
    assign posicao       = r_posicao;
    assign peso_atual    = r_peso_atual;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_quadro_peso_rx.sv
// Self-checking bench for quadro_peso_rx: directed frames plus randomized traffic
// compared every cycle against a queue-based frame model.
module tb_quadro_peso_rx;

    localparam int DIG = 2;
    localparam int TO  = 100;
    localparam int ND  = 3*DIG;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       dado = 8'h00;
    logic             dado_valido = 1'b0;
    logic             pronto, erro, pertence, abaixo, acima, peso_max_zero;
    logic [2:0]       posicao;
    logic [4*DIG-1:0] peso_atual;
    logic [1:0]       db_estado;

    quadro_peso_rx #(.DIGITOS(DIG), .TIMEOUT_CICLOS(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .dado          (dado),
        .dado_valido   (dado_valido),
        .pronto        (pronto),
        .erro          (erro),
        .pertence      (pertence),
        .abaixo        (abaixo),
        .acima         (acima),
        .peso_max_zero (peso_max_zero),
        .posicao       (posicao),
        .peso_atual    (peso_atual),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: received digits in a queue, frame phase implied by its length.
    int q[$];
    int m_idle;
    bit e_pronto, e_erro, e_pert, e_abx, e_aci, e_pmz;
    int e_pos, e_atual;

    function automatic int field(input int k);
        int v = 0;
        for (int j = 0; j < DIG; j++) v = v*10 + q[k*DIG + j];
        return v;
    endfunction

    function automatic int to_bcd(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < DIG; i++) begin
            r = r | ((x % 10) << (4*i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_estado();
        if (q.size() == 0) return 0;
        if (q.size() < ND) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        q.delete();
        m_idle = 0;
        e_pronto = 0; e_erro = 0;
        e_pert = 0; e_abx = 0; e_aci = 0; e_pmz = 1;
        e_pos = 0; e_atual = 0;
    endtask

    task automatic model_evaluate();
        int mn, mx, at;
        bit rejeita;
        mn = field(0); mx = field(1); at = field(2);
        rejeita = 0;
`ifdef QUADRO_CHECA_FAIXA_EN
        rejeita = (mn > mx);
`endif
        if (rejeita) begin
            e_erro = 1;
        end else begin
            e_pronto = 1;
            e_pert  = (at >= mn) && (at <= mx);
            e_aci   = !e_pert && (at > mx);
            e_abx   = !e_pert && !e_aci;
            e_pos   = e_aci ? 7 : (e_pert ? 3 : 0);
            e_pmz   = (mx == 0);
            e_atual = at;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_dig;
        is_dig = (b >= 8'h30) && (b <= 8'h39);
        e_pronto = 0; e_erro = 0; m_idle = 0;
        if (q.size() == 0) begin
            if (is_dig) q.push_back(int'(b) - 48);
        end else if (q.size() < ND) begin
            if (is_dig) q.push_back(int'(b) - 48);
            else begin e_erro = 1; q.delete(); end
        end else begin
            if (b == 8'h23) model_evaluate();
            else e_erro = 1;
            q.delete();
        end
    endtask

    task automatic model_idle();
        e_pronto = 0; e_erro = 0;
        if (q.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                e_erro = 1;
                q.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pronto"},   32'(pronto),        32'(e_pronto));
        check({tag, ".erro"},     32'(erro),          32'(e_erro));
        check({tag, ".exclusivo"}, 32'(pronto & erro), 32'(0));
        check({tag, ".pertence"}, 32'(pertence),      32'(e_pert));
        check({tag, ".abaixo"},   32'(abaixo),        32'(e_abx));
        check({tag, ".acima"},    32'(acima),         32'(e_aci));
        check({tag, ".pmz"},      32'(peso_max_zero), 32'(e_pmz));
        check({tag, ".posicao"},  32'(posicao),       32'(e_pos));
        check({tag, ".atual"},    32'(peso_atual),    32'(to_bcd(e_atual)));
        check({tag, ".estado"},   32'(db_estado),     32'(exp_estado()));
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        dado = b;
        dado_valido = 1'b1;
        @(negedge clock);
        dado_valido = 1'b0;
        model_byte(b);
        check_all("byte");
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            model_idle();
            check_all("idle");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] random_nondigit();
        logic [7:0] b;
        case ($urandom_range(0, 5))
            0: b = 8'h23;
            1: b = 8'h41;
            2: b = 8'h2F;
            3: b = 8'h3A;
            4: b = 8'h20;
            default: b = 8'($urandom_range(8'h3A, 8'hFF));
        endcase
        return b;
    endfunction

    task automatic random_gap();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0)      idle(TO);
        else if (r == 1) idle(TO - 1);
        else if (r < 8)  idle($urandom_range(1, 3));
    endtask

    initial begin
        #2;
        do_reset();

        send_str("105030#");
        check("d1.pertence", 32'(pertence), 32'(1));
        check("d1.atual", 32'(peso_atual), 32'h30);
        idle(2);

        send_str("105060#");
        check("d2.acima", 32'(acima), 32'(1));
        idle(1);
        send_str("105005#");
        check("d3.posicao", 32'(posicao), 32'(0));
        idle(1);

        send_str("#x");
        send_str("10A");
        check("d4.erro", 32'(erro), 32'(1));
        idle(2);

        send_str("1050");
        idle(TO);
        idle(2);
        send_str("000000#");
        check("d5.pmz", 32'(peso_max_zero), 32'(1));
        idle(1);

        send_str("10");
        idle(TO - 1);
        send_str("5030#");
        idle(1);

        send_str("501030#");
        idle(1);
        send_str("10507");
        idle(TO);
        idle(1);

        send_str("1050");
        do_reset();
        send_str("105030#");
        check("d6.pertence", 32'(pertence), 32'(1));
        idle(1);

        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                send_byte(random_nondigit());
                random_gap();
            end
            for (int i = 0; i < ND; i++) begin
                if ($urandom_range(0, 14) == 0) send_byte(random_nondigit());
                else send_byte(8'(8'h30 + $urandom_range(0, 9)));
                random_gap();
            end
            if ($urandom_range(0, 9) == 0) send_byte(random_nondigit());
            else send_byte(8'h23);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
